// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the configurable UART receiver.
//   rx_state_t          receiver FSM states
//   PAR_NONE/EVEN/ODD   parity_mode encodings (3 is treated as none)
//   cnt_width()         width of a counter that must hold 0..limit-1
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_vote.sv
// uart_rx_vote: 3-sample majority filter for the serial line.
//   clk, rst  clock and asynchronous active-low reset (history resets to idle-high)
//   s_tick    oversample strobe; one new sample shifted in per strobe
//   rx        serial line sample input
//   vote      majority of the three most recent samples
module uart_rx_vote (
    input  logic clk,
    input  logic rst,
    input  logic s_tick,
    input  logic rx,
    output logic vote
);

    logic [2:0] hist_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= '1;
        end else if (s_tick) begin
            hist_q <= {hist_q[1:0], rx};
        end
    end

    always_comb begin
        vote = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampling UART receiver, DBIT data bits (LSB first), OSR ticks
// per bit, runtime parity (none/even/odd) and one or two stop bits.
//   clk, rst      clock and asynchronous active-low reset
//   rx            serial line, idle high
//   s_tick        one-clk oversample strobe, OSR per bit period
//   parity_mode   0 none, 1 even, 2 odd, 3 none (latched at frame start)
//   two_stop      0 one stop bit, 1 two stop bits (latched at frame start)
//   rx_dout       last received data word
//   rx_done_tick  one-clk pulse when a frame completes (mid last stop bit)
//   parity_err    parity mismatch on the last frame
//   frame_err     a stop bit sampled low on the last frame
// Build option: define RX_SYNC_EN to pass rx through a 2-flop synchroniser.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DBIT = 8,
    parameter int OSR  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx,
    input  logic            s_tick,
    input  logic [1:0]      parity_mode,
    input  logic            two_stop,
    output logic [DBIT-1:0] rx_dout,
    output logic            rx_done_tick,
    output logic            parity_err,
    output logic            frame_err
);

    localparam int unsigned SW = cnt_width(OSR);
    localparam int unsigned NW = cnt_width(DBIT);
    localparam logic [SW-1:0] S_MID  = SW'(OSR / 2 - 1);
    localparam logic [SW-1:0] S_END  = SW'(OSR - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    logic rx_in;
    logic vote;

`ifdef RX_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    assign rx_in = sync_q[1];
`else
    assign rx_in = rx;
`endif

    uart_rx_vote u_vote (
        .clk    (clk),
        .rst    (rst),
        .s_tick (s_tick),
        .rx     (rx_in),
        .vote   (vote)
    );

    rx_state_t       state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] data_q, data_d;
    logic            par_q, par_d;         // running XOR of received data bits
    logic [1:0]      mode_q, mode_d;
    logic            two_q, two_d;
    logic            perr_q, perr_d;       // errors of the frame in progress
    logic            ferr_q, ferr_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            done_q, done_d;
    logic            perr_out_q, perr_out_d;
    logic            ferr_out_q, ferr_out_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            s_q        <= '0;
            n_q        <= '0;
            data_q     <= '0;
            par_q      <= 1'b0;
            mode_q     <= PAR_NONE;
            two_q      <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            dout_q     <= '0;
            done_q     <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            n_q        <= n_d;
            data_q     <= data_d;
            par_q      <= par_d;
            mode_q     <= mode_d;
            two_q      <= two_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            dout_q     <= dout_d;
            done_q     <= done_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        n_d        = n_q;
        data_d     = data_q;
        par_d      = par_q;
        mode_d     = mode_q;
        two_d      = two_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        dout_d     = dout_q;
        done_d     = 1'b0;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;

        unique case (state_q)
            IDLE: begin
                // Raw line level starts a frame; the vote filter confirms it mid start bit.
                if (!rx_in) begin
                    state_d = START;
                    s_d     = '0;
                    mode_d  = parity_mode;
                    two_d   = two_stop;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == S_MID) begin
                        if (vote) begin
                            state_d = IDLE;
                        end else begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                            par_d   = 1'b0;
                            perr_d  = 1'b0;
                            ferr_d  = 1'b0;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == S_END) begin
                        s_d    = '0;
                        data_d = {vote, data_q[DBIT-1:1]};
                        par_d  = par_q ^ vote;
                        if (n_q == N_LAST) begin
                            n_d     = '0;
                            state_d = (mode_q == PAR_EVEN || mode_q == PAR_ODD) ? PARITY : STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            PARITY: begin
                if (s_tick) begin
                    if (s_q == S_END) begin
                        s_d     = '0;
                        perr_d  = (mode_q == PAR_ODD) ? ~(par_q ^ vote) : (par_q ^ vote);
                        state_d = STOP;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == S_END) begin
                        s_d    = '0;
                        ferr_d = ferr_q | ~vote;
                        if (two_q && n_q == '0) begin
                            n_d = NW'(1);
                        end else begin
                            state_d    = IDLE;
                            done_d     = 1'b1;
                            dout_d     = data_q;
                            perr_out_d = perr_q;
                            ferr_out_d = ferr_q | ~vote;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rx_dout      = dout_q;
    assign rx_done_tick = done_q;
    assign parity_err   = perr_out_q;
    assign frame_err    = ferr_out_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed plus randomized frames checked against a frame-level
// reference (expected data, parity/framing flags and tick latency derived from
// the transmitted bit list).
module tb_uart_rx_cfg;

    localparam int DBIT = 8;
    localparam int OSR  = 16;
    localparam int M    = OSR / 2;
    localparam int TDIV = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            rx = 1'b1;
    logic            s_tick;
    logic [1:0]      parity_mode = 2'd0;
    logic            two_stop = 1'b0;
    logic [DBIT-1:0] rx_dout;
    logic            rx_done_tick;
    logic            parity_err;
    logic            frame_err;

    int errors = 0;
    int checks = 0;

    int tdiv = 0;
    int tcount = 0;
    int done_cnt = 0;
    int done_at = 0;
    bit prev_done = 1'b0;
    bit double_pulse = 1'b0;

    uart_rx_cfg #(.DBIT(DBIT), .OSR(OSR)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .s_tick       (s_tick),
        .parity_mode  (parity_mode),
        .two_stop     (two_stop),
        .rx_dout      (rx_dout),
        .rx_done_tick (rx_done_tick),
        .parity_err   (parity_err),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    assign s_tick = (tdiv == 0);

    always @(posedge clk) begin
        tdiv <= (tdiv == TDIV - 1) ? 0 : tdiv + 1;
        if (s_tick) tcount <= tcount + 1;
    end

    always @(negedge clk) begin
        if (rx_done_tick) begin
            done_cnt = done_cnt + 1;
            done_at  = tcount;
            if (prev_done) double_pulse = 1'b1;
        end
        prev_done = rx_done_tick;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns at the negedge following the next s_tick edge.
    task automatic one_tick();
        do @(negedge clk); while (s_tick !== 1'b1);
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) one_tick();
    endtask

    task automatic send_frame(input logic [DBIT-1:0] data, input logic [1:0] pm, input bit two,
                              input bit flip, input bit stop0, input bit stop1,
                              input int gbit, input int gtick, output int t0);
        bit bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < DBIT; i++) bits.push_back(data[i]);
        if (pm == 2'd1) bits.push_back((^data) ^ flip);
        else if (pm == 2'd2) bits.push_back(~(^data) ^ flip);
        bits.push_back(stop0);
        if (two) bits.push_back(stop1);
        parity_mode = pm;
        two_stop    = two;
        t0 = tcount;
        for (int i = 0; i < bits.size(); i++) begin
            // Mid-frame config changes must be ignored.
            if (i == 1) begin
                parity_mode = 2'($urandom);
                two_stop    = 1'($urandom);
            end
            for (int t = 0; t < OSR; t++) begin
                // Release the line after the last stop is sampled so a low stop is not a new start.
                if (i == bits.size() - 1 && t >= M) rx = 1'b1;
                else if (i == gbit && t == gtick) rx = ~bits[i];
                else rx = bits[i];
                one_tick();
            end
        end
        rx = 1'b1;
    endtask

    task automatic frame(input string tag, input logic [DBIT-1:0] data, input logic [1:0] pm,
                         input bit two, input bit flip, input bit stop0, input bit stop1,
                         input int gbit, input int gtick);
        int t0, dc0, p, s;
        dc0 = done_cnt;
        send_frame(data, pm, two, flip, stop0, stop1, gbit, gtick, t0);
        ticks(M + 4);
        p = (pm == 2'd1 || pm == 2'd2) ? 1 : 0;
        s = two ? 2 : 1;
        chk({tag, ".done"}, done_cnt, dc0 + 1);
        chk({tag, ".dout"}, 32'(rx_dout), 32'(data));
        chk({tag, ".perr"}, 32'(parity_err), (p == 1 && flip) ? 1 : 0);
        chk({tag, ".ferr"}, 32'(frame_err), (!stop0 || (two && !stop1)) ? 1 : 0);
        chk({tag, ".lat"}, done_at - t0, OSR * (1 + DBIT + p + s) - M);
    endtask

    initial begin
        int dc0, t0, nb;
        logic [7:0] d12;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst.dout", 32'(rx_dout), 0);
        chk("rst.done", 32'(rx_done_tick), 0);
        chk("rst.perr", 32'(parity_err), 0);
        chk("rst.ferr", 32'(frame_err), 0);
        rst = 1'b1;
        ticks(4);

        frame("t1", 8'hA5, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, -1, 0);
        frame("t2a", 8'h07, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, -1, 0);
        frame("t2b", 8'h07, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1, -1, 0);
        frame("t3", 8'h3C, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, -1, 0);

        // False start: 5 low ticks, then high
        dc0 = done_cnt;
        rx = 1'b0;
        ticks(5);
        rx = 1'b1;
        ticks(2 * OSR);
        chk("t4.nodone", done_cnt, dc0);
        chk("t4.dout", 32'(rx_dout), 32'h3C);
        chk("t4.ferr", 32'(frame_err), 1);
        frame("t4b", 8'h55, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, -1, 0);

        // Glitch on the newest vote sample of data bit 3
        frame("t5", 8'hFF, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4, M - 2);

        for (int k = 0; k < 12; k++) begin
            logic [1:0] pm;
            bit two, pbit;
            int nbits;
            pm    = 2'($urandom_range(0, 3));
            two   = 1'($urandom);
            pbit  = (pm == 2'd1 || pm == 2'd2);
            nbits = DBIT + (pbit ? 1 : 0);
            frame($sformatf("rnd%0d", k), DBIT'($urandom), pm, two, 1'($urandom),
                  1'($urandom), 1'($urandom), $urandom_range(1, nbits), $urandom_range(0, OSR - 1));
        end

        // Break: line held low completes a zero frame, then re-arms on the low line
        parity_mode = 2'd0;
        two_stop    = 1'b0;
        nb  = OSR * (1 + DBIT + 1) - M;
        dc0 = done_cnt;
        t0  = tcount;
        rx  = 1'b0;
        ticks(nb + 1);
        chk("brk.done", done_cnt, dc0 + 1);
        chk("brk.lat", done_at - t0, nb);
        chk("brk.dout", 32'(rx_dout), 0);
        chk("brk.ferr", 32'(frame_err), 1);
        chk("brk.perr", 32'(parity_err), 0);
        ticks(M - 1);
        rx = 1'b1;
        ticks(nb + 4);
        chk("brk2.done", done_cnt, dc0 + 2);
        chk("brk2.lat", done_at - t0, 2 * nb);
        chk("brk2.dout", 32'(rx_dout), (1 << DBIT) - 1);
        chk("brk2.ferr", 32'(frame_err), 0);

        // Frame with both errors, so the reset below has flags to clear
        frame("pre6", 8'h81, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1, -1, 0);

        // Reset during data bits of 0x12
        d12 = 8'h12;
        dc0 = done_cnt;
        parity_mode = 2'd0;
        two_stop    = 1'b0;
        rx = 1'b0;
        ticks(OSR);
        for (int b = 0; b < 3; b++) begin
            rx = d12[b];
            ticks(OSR);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        chk("t6.rdout", 32'(rx_dout), 0);
        chk("t6.rperr", 32'(parity_err), 0);
        chk("t6.rferr", 32'(frame_err), 0);
        rst = 1'b1;
        ticks(2 * OSR);
        chk("t6.nodone", done_cnt, dc0);
        frame("t6b", 8'h34, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, -1, 0);
        chk("t6.total", done_cnt, dc0 + 1);

        chk("single_pulse", 32'(double_pulse), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
